// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the memory (slave).
// mem_req/mem_we/mem_addr/mem_wdata are registered by the master; mem_ack pulses once per access.
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: issues one req/ack bus transaction per aligned
// load/store, stalls the pipeline until it completes, and flags misalignment and bus timeouts.
module mem_access_unit #(
    parameter int unsigned TIMEOUT       = 16,
    parameter logic [31:0] DEFAULT_RDATA = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            MEM_ALUOut,
    input  logic [31:0]            MEM_WriteData,
    input  logic                   MEM_MemRead,
    input  logic                   MEM_MemWrite,
    mem_access_unit_if.master      bus,
    output logic [31:0]            MEM_dataMEMOut,
    output logic                   mem_stall,
    output logic                   misalign_exc,
    output logic                   bus_err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] data_out_q, data_out_d;
    logic        bus_err_q, bus_err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic access, is_wr, aligned;

    assign access  = MEM_MemRead | MEM_MemWrite;
    assign is_wr   = MEM_MemWrite;
    assign aligned = (MEM_ALUOut[1:0] == 2'b00);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        data_out_d   = data_out_q;
        bus_err_d    = 1'b0;
        cnt_d        = cnt_q;
        mem_stall    = 1'b0;
        misalign_exc = 1'b0;

        case (state_q)
            IDLE: begin
                if (access && aligned) begin
                    mem_addr_d = {MEM_ALUOut[31:2], 2'b00};
                    if (is_wr) mem_wdata_d = MEM_WriteData;
                    mem_we_d   = is_wr;
                    mem_req_d  = 1'b1;
                    cnt_d      = 8'd0;
                    mem_stall  = 1'b1;
                    state_d    = WAIT;
                end else if (access) begin
                    misalign_exc = 1'b1;
                    if (!is_wr) data_out_d = DEFAULT_RDATA;
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                // Direction is taken from the latched mem_we, since inputs are frozen here anyway.
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_we_q) data_out_d = bus.mem_rdata;
                    state_d   = DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (!mem_we_q) data_out_d = DEFAULT_RDATA;
                    state_d   = DONE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            data_out_q  <= 32'd0;
            bus_err_q   <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            data_out_q  <= data_out_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign MEM_dataMEMOut  = data_out_q;
    assign bus_err         = bus_err_q;

endmodule
